// File: rtl/afb_acc_reg_master.sv
// afb_acc_reg_master
// AFB initiator for the accelerator register interface. A local register
// read/write command becomes one AFB_ACCELERATOR_REQUEST pipe write; the
// matching AFB_ACCELERATOR_RESPONSE pipe read is returned to the host.
// Only one transaction is ever outstanding. A timeout on the request or
// response leg aborts the transaction and locks the block (afb_hung) until
// reset, so a dead accelerator cannot stall the host.
//
// Handshakes: every channel transfers on a cycle where its valid-side signal
// (cmd_valid, rsp_valid, write_req, ack of read pipe) and its ready-side signal
// (cmd_ready, rsp_ready, write_ack, read_req) are both high; a valid-side
// signal, once raised, holds its payload stable until that transfer.
module afb_acc_reg_master #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_read,
    input  logic [4:0]  cmd_reg_idx,
    input  logic [3:0]  cmd_byte_mask,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_error,
    output logic        rsp_timeout,
    output logic        afb_hung,
    output logic        AFB_ACCELERATOR_REQUEST_pipe_write_req,
    input  logic        AFB_ACCELERATOR_REQUEST_pipe_write_ack,
    output logic [73:0] AFB_ACCELERATOR_REQUEST_pipe_write_data,
    output logic        AFB_ACCELERATOR_RESPONSE_pipe_read_req,
    input  logic        AFB_ACCELERATOR_RESPONSE_pipe_read_ack,
    input  logic [32:0] AFB_ACCELERATOR_RESPONSE_pipe_read_data,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEND     = 3'd1,
        S_WAIT_RSP = 3'd2,
        S_DELIVER  = 3'd3,
        S_ABORT    = 3'd4,
        S_HUNG     = 3'd5
    } state_t;

    // A zero timeout means the accelerator is trusted to answer eventually.
    localparam bit            TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] to_cnt_q;
    logic            to_expired;
    logic            cmd_xfer;
    logic            wr_ack;
    logic            rd_ack;
    logic            enter_abort;
    logic [35:0]     cmd_addr;
    logic [73:0]     cmd_word;
    logic [73:0]     req_word_q;
    logic [31:0]     rsp_data_q;
    logic            rsp_error_q;
    logic            rsp_timeout_q;
    logic            hung_q;

    assign cmd_xfer    = cmd_valid & cmd_ready;
    assign wr_ack      = AFB_ACCELERATOR_REQUEST_pipe_write_ack;
    assign rd_ack      = AFB_ACCELERATOR_RESPONSE_pipe_read_ack;
    assign to_expired  = TO_EN && (to_cnt_q == TO_LAST);
    assign enter_abort = (state_d == S_ABORT) && (state_q != S_ABORT);

    // Register index is word-aligned into the 36-bit AFB address.
    assign cmd_addr = {29'd0, cmd_reg_idx, 2'b00};
    assign cmd_word = {1'b0, cmd_read, (cmd_read ? 4'h0 : cmd_byte_mask),
                       cmd_addr, (cmd_read ? 32'h0 : cmd_wdata)};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state decode; an ack on the last allowed cycle takes the normal path.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (cmd_xfer) state_d = S_SEND;
            S_SEND: begin
                if (wr_ack)          state_d = S_WAIT_RSP;
                else if (to_expired) state_d = S_ABORT;
            end
            S_WAIT_RSP: begin
                if (rd_ack)          state_d = S_DELIVER;
                else if (to_expired) state_d = S_ABORT;
            end
            S_DELIVER:  if (rsp_ready) state_d = S_IDLE;
            S_ABORT:    if (rsp_ready) state_d = S_HUNG;
            S_HUNG:     state_d = S_HUNG;
            default:    state_d = S_IDLE;
        endcase
    end

    // Timeout counter: cycles spent in the current SEND or WAIT_RSP visit.
    always_ff @(posedge clk) begin
        if (reset)                                         to_cnt_q <= '0;
        else if (state_d != state_q)                       to_cnt_q <= '0;
        else if (state_q == S_SEND || state_q == S_WAIT_RSP) to_cnt_q <= to_cnt_q + TO_W'(1);
    end

    // Request word captured at command accept, held until the next accept.
    always_ff @(posedge clk) begin
        if (reset)         req_word_q <= '0;
        else if (cmd_xfer) req_word_q <= cmd_word;
    end

    // Response fields: loaded from the accelerator or forced by an abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            hung_q        <= 1'b0;
        end else if (state_q == S_WAIT_RSP && rd_ack) begin
            rsp_data_q    <= req_word_q[72] ? AFB_ACCELERATOR_RESPONSE_pipe_read_data[31:0] : 32'h0;
            rsp_error_q   <= AFB_ACCELERATOR_RESPONSE_pipe_read_data[32];
            rsp_timeout_q <= 1'b0;
        end else if (enter_abort) begin
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b1;
            rsp_timeout_q <= 1'b1;
            hung_q        <= 1'b1;
        end
    end

    // Handshake outputs decode from state; cmd_ready is also held low in reset.
    assign cmd_ready = (state_q == S_IDLE) && !reset;
    assign rsp_valid = (state_q == S_DELIVER) || (state_q == S_ABORT);
    assign AFB_ACCELERATOR_REQUEST_pipe_write_req  = (state_q == S_SEND);
    assign AFB_ACCELERATOR_RESPONSE_pipe_read_req  = (state_q == S_WAIT_RSP);
    assign AFB_ACCELERATOR_REQUEST_pipe_write_data = req_word_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_error   = rsp_error_q;
    assign rsp_timeout = rsp_timeout_q;
    assign afb_hung    = hung_q;
    assign dbg_state   = state_q;

endmodule
